// File: rtl/mux_pkg.sv
// mux_pkg: shared constants and types for the round-robin mux feeder.
package mux_pkg;
  localparam int WIDTH_DEFAULT = 4;
  localparam logic SEL_A = 1'b1;
  localparam logic SEL_B = 1'b0;
  typedef enum logic {IDLE, GRANT} arb_state_t;
endpackage

// File: rtl/op_buffer.sv
// op_buffer: one-entry operand register; frozen while full, freed by clr_i.
module op_buffer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             clr_i,
  output logic             ready_o,
  output logic             full_o,
  output logic [WIDTH-1:0] data_o
);
  logic             full_q, full_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             take;
  assign take    = valid_i && !full_q;
  assign full_d  = take ? 1'b1 : (clr_i ? 1'b0 : full_q);
  assign data_d  = take ? data_i : data_q;
  assign ready_o = !full_q;
  assign full_o  = full_q;
  assign data_o  = data_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end
endmodule

// File: rtl/mux_arb_rr.sv
// mux_arb_rr: buffers one operand per producer and feeds mux2x1 with a
// round-robin select held stable for as long as a grant is offered.
module mux_arb_rr
  import mux_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ready,
  output logic [WIDTH-1:0] ia,
  output logic [WIDTH-1:0] ib,
  output logic             chave,
  output logic             out_valid,
  input  logic             out_ready
);
  arb_state_t state_q, state_d;
  logic       chave_q, chave_d, ptr_q, ptr_d;
  logic       a_full, b_full, consume, other_full;
  assign consume    = (state_q == GRANT) && out_ready;
  assign other_full = (chave_q == SEL_A) ? b_full : a_full;
  op_buffer #(.WIDTH(WIDTH)) u_buf_a (
    .clk(clk), .rst(rst), .valid_i(a_valid), .data_i(a_data),
    .clr_i(consume && chave_q == SEL_A),
    .ready_o(a_ready), .full_o(a_full), .data_o(ia)
  );
  op_buffer #(.WIDTH(WIDTH)) u_buf_b (
    .clk(clk), .rst(rst), .valid_i(b_valid), .data_i(b_data),
    .clr_i(consume && chave_q == SEL_B),
    .ready_o(b_ready), .full_o(b_full), .data_o(ib)
  );
  // Only registered full flags are seen, so a same-cycle refill waits an edge.
  always_comb begin
    state_d = state_q;
    chave_d = chave_q;
    ptr_d   = ptr_q;
    if (state_q == IDLE) begin
      state_d = (a_full || b_full) ? GRANT : IDLE;
      chave_d = !(a_full || b_full) ? chave_q :
                (a_full && (!b_full || ptr_q == SEL_A)) ? SEL_A : SEL_B;
    end else if (out_ready) begin
      ptr_d   = !chave_q;
      state_d = other_full ? GRANT : IDLE;
      chave_d = other_full ? !chave_q : chave_q;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      chave_q <= SEL_A;
      ptr_q   <= SEL_A;
    end else begin
      state_q <= state_d;
      chave_q <= chave_d;
      ptr_q   <= ptr_d;
    end
  end
  assign chave     = chave_q;
  assign out_valid = (state_q == GRANT);
endmodule

// File: tb/tb_mux_arb_rr.sv
// tb_mux_arb_rr: directed vector table, corner sequences and random traffic
// checked against a side-indexed reference model.
module tb_mux_arb_rr;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       a_valid = 1'b0, b_valid = 1'b0, out_ready = 1'b0;
  logic [3:0] a_data = 4'h0, b_data = 4'h0;
  logic       a_ready, b_ready, chave, out_valid;
  logic [3:0] ia, ib;
  int checks = 0, errors = 0;

  mux_arb_rr #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
    .ia(ia), .ib(ib), .chave(chave),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  // Model: side 0 = A, side 1 = B; granted side or -1 when nothing offered.
  int         m_full [2];
  logic [3:0] m_data [2];
  int         m_g, m_ptr;
  logic       m_ch;

  task automatic model_edge();
    int pf [2];
    int o;
    if (rst) begin
      m_full = '{0, 0};
      m_data = '{4'h0, 4'h0};
      m_g = -1;
      m_ptr = 0;
      m_ch = 1'b1;
    end else begin
      pf = m_full;
      if (a_valid && pf[0] == 0) begin m_data[0] = a_data; m_full[0] = 1; end
      if (b_valid && pf[1] == 0) begin m_data[1] = b_data; m_full[1] = 1; end
      if (m_g >= 0) begin
        if (out_ready) begin
          o = 1 - m_g;
          m_full[m_g] = 0;
          m_ptr = o;
          m_g = (pf[o] != 0) ? o : -1;
        end
      end else if (pf[0] != 0 && pf[1] != 0) m_g = m_ptr;
      else if (pf[0] != 0) m_g = 0;
      else if (pf[1] != 0) m_g = 1;
      if (m_g >= 0) m_ch = (m_g == 0);
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".out_valid"}, int'(out_valid), int'(m_g >= 0));
    chk({tag, ".chave"}, int'(chave), int'(m_ch));
    chk({tag, ".ia"}, int'(ia), int'(m_data[0]));
    chk({tag, ".ib"}, int'(ib), int'(m_data[1]));
    chk({tag, ".a_ready"}, int'(a_ready), int'(m_full[0] == 0));
    chk({tag, ".b_ready"}, int'(b_ready), int'(m_full[1] == 0));
  endtask

  task automatic drive(input logic r, input logic av, input logic [3:0] ad,
                       input logic bv, input logic [3:0] bd, input logic ordy);
    rst = r; a_valid = av; a_data = ad; b_valid = bv; b_data = bd; out_ready = ordy;
  endtask

  typedef struct {
    logic r, av; logic [3:0] ad; logic bv; logic [3:0] bd; logic ordy;
    logic ov, ch; logic [3:0] xa, xb; logic ar, br;
  } vec_t;
  vec_t vec [13];

  initial begin
    int na, nb, nexp;
    logic acc_a, acc_b;
    vec[0]  = '{1'b1, 1'b1, 4'h5, 1'b1, 4'h6, 1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 1'b1, 1'b1};
    vec[1]  = '{1'b1, 1'b1, 4'h5, 1'b1, 4'h6, 1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 1'b1, 1'b1};
    vec[2]  = '{1'b0, 1'b1, 4'h1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 4'h1, 4'h0, 1'b0, 1'b1};
    vec[3]  = '{1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 4'h1, 4'h0, 1'b0, 1'b1};
    vec[4]  = '{1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 4'h1, 4'h0, 1'b1, 1'b1};
    vec[5]  = '{1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 1'b1, 1'b1};
    vec[6]  = '{1'b0, 1'b1, 4'h1, 1'b1, 4'h2, 1'b1, 1'b0, 1'b1, 4'h1, 4'h2, 1'b0, 1'b0};
    vec[7]  = '{1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 4'h1, 4'h2, 1'b0, 1'b0};
    vec[8]  = '{1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 4'h1, 4'h2, 1'b1, 1'b0};
    vec[9]  = '{1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h1, 4'h2, 1'b1, 1'b1};
    vec[10] = '{1'b0, 1'b1, 4'h3, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h3, 4'h2, 1'b0, 1'b1};
    vec[11] = '{1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 4'h3, 4'h2, 1'b0, 1'b1};
    vec[12] = '{1'b0, 1'b0, 4'h0, 1'b1, 4'h4, 1'b0, 1'b1, 1'b1, 4'h3, 4'h4, 1'b0, 1'b0};

    foreach (vec[i]) begin
      drive(vec[i].r, vec[i].av, vec[i].ad, vec[i].bv, vec[i].bd, vec[i].ordy);
      tick();
      chk($sformatf("vec%0d.out_valid", i), int'(out_valid), int'(vec[i].ov));
      chk($sformatf("vec%0d.chave", i), int'(chave), int'(vec[i].ch));
      chk($sformatf("vec%0d.ia", i), int'(ia), int'(vec[i].xa));
      chk($sformatf("vec%0d.ib", i), int'(ib), int'(vec[i].xb));
      chk($sformatf("vec%0d.a_ready", i), int'(a_ready), int'(vec[i].ar));
      chk($sformatf("vec%0d.b_ready", i), int'(b_ready), int'(vec[i].br));
    end

    // Backpressure: grant on A held with both full, producers still pushing.
    drive(1'b0, 1'b1, 4'h9, 1'b1, 4'h9, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold.out_valid", int'(out_valid), 1);
      chk("hold.chave", int'(chave), 1);
      chk("hold.ia", int'(ia), 3);
      chk("hold.ib", int'(ib), 4);
      chk("hold.ready", int'({a_ready, b_ready}), 0);
    end
    drive(1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
    tick();
    chk("drain.chave", int'(chave), 0);
    chk("drain.out_valid", int'(out_valid), 1);
    chk("drain.ib", int'(ib), 4);
    tick();
    chk("drain.done", int'(out_valid), 0);
    check_model("drain");

    // Reset in the middle of a grant with both buffers full.
    drive(1'b0, 1'b1, 4'h7, 1'b1, 4'h8, 1'b0);
    tick();
    tick();
    chk("rstmid.pre_valid", int'(out_valid), 1);
    drive(1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0);
    tick();
    chk("rstmid.out_valid", int'(out_valid), 0);
    chk("rstmid.ready", int'({a_ready, b_ready}), 3);
    chk("rstmid.ia", int'(ia), 0);
    chk("rstmid.ib", int'(ib), 0);
    drive(1'b0, 1'b1, 4'hA, 1'b1, 4'hB, 1'b0);
    tick();
    drive(1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
    tick();
    chk("rstmid.ptr_a", int'(chave), 1);
    chk("rstmid.first", int'(ia), 10);
    tick();
    chk("rstmid.second", int'(chave ? ia : ib), 11);
    tick();
    check_model("rstmid");

    // Fairness: both producers saturated, consumer always ready.
    drive(1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
    tick();
    rst = 1'b0; a_valid = 1'b1; b_valid = 1'b1;
    na = 1; nb = 2; nexp = 1;
    for (int i = 0; i < 40; i++) begin
      a_data = 4'(na); b_data = 4'(nb);
      acc_a = a_ready; acc_b = b_ready;
      if (out_valid) begin
        chk("fair.mux", int'(chave ? ia : ib), nexp % 16);
        chk("fair.sel", int'(chave), nexp % 2);
        nexp++;
      end
      tick();
      if (acc_a) na += 2;
      if (acc_b) nb += 2;
      check_model("fair");
    end
    chk("fair.progress", int'(nexp > 15), 1);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 39) == 0, 1'($urandom), 4'($urandom),
            1'($urandom), 4'($urandom), $urandom_range(0, 3) != 0);
      tick();
      check_model("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mux_arb_rr.md
Name: mux_arb_rr

Overview:
Upstream feeder for the 2:1 operand mux (mux2x1). Two independent producers hand 4-bit operands over valid/ready. The block buffers one operand per producer and arbitrates round-robin between them. It drives the mux's ia, ib and chave (select), and presents a valid/ready handshake to the consumer downstream of the mux. It guarantees that chave, ia and ib are stable for the whole time a selection is offered.

Parameters:
- WIDTH, 4: operand width; matches the mux data inputs.

Ports:
- clk, input, 1: single clock; all state updates on rising edge.
- rst, input, 1: synchronous, active-high reset.
- a_valid, input, 1: producer A has an operand.
- a_data, input, WIDTH: producer A operand.
- a_ready, output, 1: A buffer can accept.
- b_valid, input, 1: producer B has an operand.
- b_data, input, WIDTH: producer B operand.
- b_ready, output, 1: B buffer can accept.
- ia, output, WIDTH: registered A operand to mux input ia.
- ib, output, WIDTH: registered B operand to mux input ib.
- chave, output, 1: mux select; 1 = ia, 0 = ib.
- out_valid, output, 1: the mux output is a granted operand.
- out_ready, input, 1: consumer accepts the mux output.

Behaviour:
- Reset values (rst=1 at an edge):
  - a_ready=b_ready=1 after reset; both buffers empty.
  - ia=ib=0, chave=1, out_valid=0.
  - Priority pointer = A; FSM = IDLE.
- Reset mid-transfer discards both buffered operands and any pending grant; nothing is replayed.
- Buffers:
  - a_ready = !a_full, combinational from the registered flag.
  - a_valid && a_ready at an edge: ia <= a_data, a_full <= 1.
  - B side is identical, using ib and b_full.
  - A full buffer never takes new data, so ia and ib are frozen while full.
- FSM states: IDLE, GRANT.
- IDLE:
  - No buffer full: stay in IDLE, out_valid=0, chave holds its last value.
  - Exactly one full: grant it.
  - Both full: grant the side named by the priority pointer.
  - On grant: chave <= (A?1:0), out_valid <= 1, go to GRANT.
- GRANT:
  - out_valid=1; chave, ia, ib held.
  - out_ready=0: remain in GRANT indefinitely.
  - out_ready=1 at an edge:
    - Clear the granted buffer's full flag.
    - Priority pointer <= the other side.
    - If the other buffer is full at that edge, grant it directly (chave flips, out_valid stays 1). Otherwise out_valid <= 0 and go to IDLE.
- Latency:
  - Operand accepted at edge N → out_valid=1 after edge N+1, if nothing else is granted.
  - Back-to-back alternation gives one grant per cycle while the consumer is always ready.
- Simultaneous events:
  - Accept into the ungranted buffer in the same cycle as a consume: the new data is captured, and that buffer is eligible for the direct-grant check only from the next edge on.
  - Releasing a buffer and refilling it in the same cycle is not possible, because ready is taken from the registered full flag. A freed buffer reasserts ready one cycle after the consume.
- Fairness: with both producers saturated, grants strictly alternate A, B, A, B. No side waits more than one grant.

Decomposition:
- Package mux_pkg:
  - WIDTH_DEFAULT = 4.
  - SEL_A = 1'b1, SEL_B = 1'b0.
  - typedef enum {IDLE, GRANT} arb_state_t.
- Sub-module op_buffer (WIDTH): one-entry register with valid/ready in, full flag out, and a clear input. Instantiated twice, for A and B.
- Arbiter FSM and priority pointer live in mux_arb_rr.

Test Plan:
- Reset: assert rst for 2 cycles with a_valid=b_valid=1 → ia=ib=0, chave=1, out_valid=0, a_ready=b_ready=1 throughout.
- Single operand:
  - a_data=4'h1 accepted at edge 1 → edge 2: out_valid=1, chave=1, ia=4'h1.
  - out_ready=1 → out_valid=0 at edge 3; a_ready=1 again.
- Simultaneous arrival: a_data=4'h1 and b_data=4'h2 at the same edge, out_ready=1 → outputs ia (chave=1, value 1), then next cycle ib (chave=0, value 2), then out_valid=0.
- Backpressure:
  - Hold out_ready=0 for 5 cycles with a grant pending → chave, ia, ib and out_valid constant; a_ready=b_ready=0 once both are full.
  - Release out_ready → drain order A then B.
- Fairness: both producers always valid (A sends 1,3,5..., B sends 2,4,6...), out_ready=1 → chave sequence 1,0,1,0..., mux output 1,2,3,4....
- Reset mid-GRANT: pulse rst while out_valid=1 with both buffers full → next cycle out_valid=0, both ready=1, pointer=A; the old operands never appear.
